// File: rtl/ps2_choice_decoder_if.sv
// PS/2 keyboard pins and the decoded player-1 choice outputs.
// The decoder uses the slave view; a keyboard model or bench drives the master view.
interface ps2_choice_decoder_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [2:0] p1_choice;
    logic       choice_valid;
    logic       frame_err;

    modport master (
        output ps2_clk,
        output ps2_data,
        input  p1_choice,
        input  choice_valid,
        input  frame_err
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output p1_choice,
        output choice_valid,
        output frame_err
    );
endinterface

// File: rtl/ps2_choice_decoder.sv
// PS/2 keyboard receiver that turns three make codes into a one-hot player-1 move.
// Break (F0) and extended (E0) prefixed codes are swallowed; framing faults pulse frame_err.
module ps2_choice_decoder #(
    parameter int         FILTER_LEN = 8,
    parameter int         TIMEOUT    = 100000,
    parameter logic [7:0] KEY_2      = 8'h1C,
    parameter logic [7:0] KEY_1      = 8'h1B,
    parameter logic [7:0] KEY_0      = 8'h23
) (
    input  logic                clk,
    input  logic                reset,
    ps2_choice_decoder_if.slave bus
);
    localparam int FLT_W = $clog2(FILTER_LEN + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic             ps2_clk_p0, ps2_clk_p1;
    logic             ps2_data_p0, ps2_data_p1;
    logic             filt_clk;
    logic [FLT_W-1:0] flt_cnt;
    logic             strobe;

    state_t           state, state_nxt;
    logic [7:0]       shift, shift_nxt;
    logic [2:0]       bit_cnt, bit_cnt_nxt;
    logic             par, par_nxt;
    logic [TO_W-1:0]  to_cnt, to_cnt_nxt;
    logic             byte_ok, err;

    logic             brk_flag, ext_flag;
    logic [2:0]       choice;
    logic             choice_valid, frame_err;

    // Two-flop synchronizers; idle PS/2 lines are high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ps2_clk_p0  <= 1'b1;
            ps2_clk_p1  <= 1'b1;
            ps2_data_p0 <= 1'b1;
            ps2_data_p1 <= 1'b1;
        end else begin
            ps2_clk_p0  <= bus.ps2_clk;
            ps2_clk_p1  <= ps2_clk_p0;
            ps2_data_p0 <= bus.ps2_data;
            ps2_data_p1 <= ps2_data_p0;
        end
    end

    // Filtered clock flips on the FILTER_LEN-th consecutive differing sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_clk <= 1'b1;
            flt_cnt  <= '0;
        end else if (ps2_clk_p1 == filt_clk) begin
            flt_cnt  <= '0;
        end else if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
            filt_clk <= ps2_clk_p1;
            flt_cnt  <= '0;
        end else begin
            flt_cnt  <= flt_cnt + 1'b1;
        end
    end

    assign strobe = filt_clk & ~ps2_clk_p1 & (flt_cnt == FLT_W'(FILTER_LEN - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            par     <= 1'b0;
            to_cnt  <= '0;
        end else begin
            state   <= state_nxt;
            shift   <= shift_nxt;
            bit_cnt <= bit_cnt_nxt;
            par     <= par_nxt;
            to_cnt  <= to_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift;
        bit_cnt_nxt = bit_cnt;
        par_nxt     = par;
        to_cnt_nxt  = '0;
        byte_ok     = 1'b0;
        err         = 1'b0;
        if (state != IDLE) begin
            to_cnt_nxt = to_cnt + 1'b1;
        end
        if (strobe) begin
            to_cnt_nxt = '0;
            unique case (state)
                IDLE: begin
                    if (!ps2_data_p1) begin
                        state_nxt   = DATA;
                        bit_cnt_nxt = '0;
                    end else begin
                        err = 1'b1;
                    end
                end
                DATA: begin
                    shift_nxt   = {ps2_data_p1, shift[7:1]};
                    bit_cnt_nxt = bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = PARITY;
                    end
                end
                PARITY: begin
                    par_nxt   = ps2_data_p1;
                    state_nxt = STOP;
                end
                STOP: begin
                    state_nxt = IDLE;
                    if (ps2_data_p1 && (^{shift, par})) begin
                        byte_ok = 1'b1;
                    end else begin
                        err = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end else if ((state != IDLE) && (to_cnt == TO_W'(TIMEOUT - 1))) begin
            // Keyboard stalled mid-frame: drop whatever was collected.
            state_nxt   = IDLE;
            shift_nxt   = '0;
            bit_cnt_nxt = '0;
            to_cnt_nxt  = '0;
            err         = 1'b1;
        end
    end

    // Byte decode: prefixes arm a flag that swallows the next code.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            brk_flag     <= 1'b0;
            ext_flag     <= 1'b0;
            choice       <= 3'b100;
            choice_valid <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            choice_valid <= 1'b0;
            frame_err    <= err;
            if (byte_ok) begin
                if (shift == 8'hF0) begin
                    brk_flag <= 1'b1;
                end else if (shift == 8'hE0) begin
                    ext_flag <= 1'b1;
                end else if (brk_flag || ext_flag) begin
                    brk_flag <= 1'b0;
                    ext_flag <= 1'b0;
                end else if (shift == KEY_2) begin
                    choice       <= 3'b100;
                    choice_valid <= 1'b1;
                end else if (shift == KEY_1) begin
                    choice       <= 3'b010;
                    choice_valid <= 1'b1;
                end else if (shift == KEY_0) begin
                    choice       <= 3'b001;
                    choice_valid <= 1'b1;
                end
            end
        end
    end

    assign bus.p1_choice    = choice;
    assign bus.choice_valid = choice_valid;
    assign bus.frame_err    = frame_err;
endmodule

// File: tb/tb_ps2_choice_decoder.sv
// Randomized and directed bench for ps2_choice_decoder against a frame-level keyboard model.
`timescale 1ns/1ps
module tb_ps2_choice_decoder;
    localparam int FL = 4;
    localparam int TO = 50;
    localparam int H  = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    ps2_choice_decoder_if bus();

    ps2_choice_decoder #(
        .FILTER_LEN (FL),
        .TIMEOUT    (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int v_cnt    = 0;
    int e_cnt    = 0;
    int last_v_cyc = -1;
    int fall_cyc   = 0;
    int seq_v      = 0;
    bit overlap_bad = 1'b0;
    bit onehot_bad  = 1'b0;

    logic [2:0] m_choice = 3'b100;
    bit         m_brk    = 1'b0;
    bit         m_ext    = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (reset) begin
            if (bus.choice_valid) begin
                v_cnt++;
                last_v_cyc = cyc;
            end
            if (bus.frame_err) e_cnt++;
            if (bus.choice_valid && bus.frame_err) overlap_bad = 1'b1;
            if (!(bus.p1_choice inside {3'b001, 3'b010, 3'b100})) onehot_bad = 1'b1;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        bus.ps2_data = b;
        if (glitch) begin
            wait_cyc(4);
            bus.ps2_clk = 1'b0;
            wait_cyc(FL - 1);
            bus.ps2_clk = 1'b1;
            wait_cyc(H - 4 - (FL - 1));
        end else begin
            wait_cyc(H);
        end
        bus.ps2_clk = 1'b0;
        fall_cyc = cyc;
        wait_cyc(H);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input logic stop,
                              input int glitch_at, input int nbits);
        logic [10:0] f;
        f = {stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(f[i], i == glitch_at);
        bus.ps2_data = 1'b1;
    endtask

    // Keyboard-level expectation: what one complete frame should do to the outputs.
    task automatic model_frame(input logic [7:0] b, input bit bad_par, input logic stop,
                               output int ev, output int ee);
        ev = 0;
        ee = 0;
        if (bad_par || !stop) ee = 1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'hE0) m_ext = 1'b1;
        else if (m_brk || m_ext) begin
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
        else if (b == 8'h1C) begin m_choice = 3'b100; ev = 1; end
        else if (b == 8'h1B) begin m_choice = 3'b010; ev = 1; end
        else if (b == 8'h23) begin m_choice = 3'b001; ev = 1; end
    endtask

    task automatic run_frame(input string tag, input logic [7:0] b, input bit bad_par,
                             input logic stop, input int glitch_at);
        int ev, ee;
        v_cnt = 0;
        e_cnt = 0;
        last_v_cyc = -1;
        model_frame(b, bad_par, stop, ev, ee);
        send_frame(b, bad_par, stop, glitch_at, 11);
        wait_cyc(H);
        chk({tag, "_choice"}, 32'(bus.p1_choice), 32'(m_choice));
        chk({tag, "_valid"}, v_cnt, ev);
        chk({tag, "_err"}, e_cnt, ee);
        if (ev == 1 && v_cnt == 1)
            chk({tag, "_latency"}, 32'((last_v_cyc - fall_cyc) inside {[FL + 1 : FL + 3]}), 1);
        seq_v += v_cnt;
    endtask

    initial begin
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        reset = 1'b0;
        wait_cyc(5);
        chk("rst_choice", 32'(bus.p1_choice), 3'b100);
        chk("rst_valid", 32'(bus.choice_valid), 0);
        chk("rst_err", 32'(bus.frame_err), 0);
        reset = 1'b1;
        wait_cyc(10);
        chk("post_rst_choice", 32'(bus.p1_choice), 3'b100);
        chk("post_rst_quiet", v_cnt + e_cnt, 0);

        run_frame("bad_parity", 8'h1C, 1'b1, 1'b1, -1);
        run_frame("key1", 8'h1B, 1'b0, 1'b1, -1);

        seq_v = 0;
        run_frame("seq_a", 8'h23, 1'b0, 1'b1, -1);
        run_frame("seq_brk", 8'hF0, 1'b0, 1'b1, -1);
        run_frame("seq_b", 8'h23, 1'b0, 1'b1, -1);
        chk("seq_valid_total", seq_v, 1);

        // Partial frame followed by silence longer than the timeout.
        v_cnt = 0;
        e_cnt = 0;
        send_frame(8'h1B, 1'b0, 1'b1, -1, 4);
        wait_cyc(TO + 40);
        chk("timeout_err", e_cnt, 1);
        chk("timeout_valid", v_cnt, 0);
        chk("timeout_choice", 32'(bus.p1_choice), 3'b001);
        run_frame("after_timeout", 8'h1B, 1'b0, 1'b1, -1);

        // Asynchronous reset in the middle of a frame.
        send_frame(8'h23, 1'b0, 1'b1, -1, 5);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_choice", 32'(bus.p1_choice), 3'b100);
        chk("async_rst_err", 32'(bus.frame_err), 0);
        m_choice = 3'b100;
        m_brk = 1'b0;
        m_ext = 1'b0;
        wait_cyc(3);
        reset = 1'b1;
        wait_cyc(5);
        run_frame("after_reset", 8'h1B, 1'b0, 1'b1, -1);

        run_frame("glitch", 8'h1C, 1'b0, 1'b1, 3);
        run_frame("typematic", 8'h1C, 1'b0, 1'b1, -1);
        run_frame("ext_prefix", 8'hE0, 1'b0, 1'b1, -1);
        run_frame("ext_code", 8'h1B, 1'b0, 1'b1, -1);
        run_frame("unmapped", 8'h15, 1'b0, 1'b1, -1);
        run_frame("bad_stop", 8'h23, 1'b0, 1'b0, -1);

        for (int n = 0; n < 40; n++) begin
            int r;
            logic [7:0] b;
            r = $urandom_range(0, 9);
            case (r)
                0, 1: b = 8'h1C;
                2, 3: b = 8'h1B;
                4, 5: b = 8'h23;
                6:    b = 8'hF0;
                7:    b = 8'hE0;
                default: b = 8'($urandom_range(0, 255));
            endcase
            run_frame("rand", b, $urandom_range(0, 7) == 0, $urandom_range(0, 9) != 0, -1);
        end

        chk("valid_err_overlap", 32'(overlap_bad), 0);
        chk("choice_onehot", 32'(onehot_bad), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ps2_choice_decoder.md
PS2_CHOICE_DECODER -- requirements
Module: ps2_choice_decoder

Interface
REQ-001 Parameter FILTER_LEN, default 8: consecutive identical synchronized ps2_clk samples required to accept a level change.
REQ-002 Parameter TIMEOUT, default 100000: clk cycles without a filtered ps2_clk falling edge before a partial frame is aborted (1 ms at 100 MHz).
REQ-003 Parameter KEY_2, default 8'h1C: make code mapped to p1_choice 3'b100.
REQ-004 Parameter KEY_1, default 8'h1B: make code mapped to p1_choice 3'b010.
REQ-005 Parameter KEY_0, default 8'h23: make code mapped to p1_choice 3'b001.
REQ-006 clk  input  1  system clock, 100 MHz, all logic on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-008 ps2_clk  input  1  PS/2 keyboard clock, asynchronous to clk.
REQ-009 ps2_data  input  1  PS/2 keyboard data, asynchronous to clk.
REQ-010 p1_choice  output  3  one-hot player-1 move, feeds the game core's p1_choice input.
REQ-011 choice_valid  output  1  one-cycle pulse when p1_choice is (re)loaded from a key press.
REQ-012 frame_err  output  1  one-cycle pulse on parity, start, stop or timeout error.

Function
REQ-013 ps2_clk and ps2_data SHALL each pass a 2-flop synchronizer before any use.
REQ-014 Filtered ps2_clk SHALL change level only after FILTER_LEN consecutive equal synchronized samples; a falling edge of the filtered clock is the sample strobe.
REQ-015 FSM states SHALL be IDLE, DATA, PARITY, STOP; transitions only on sample strobe except timeout.
REQ-016 IDLE: strobe with data 0 -> DATA, bit counter 0; strobe with data 1 -> stay IDLE, pulse frame_err.
REQ-017 DATA: shift 8 bits LSB first; after 8th strobe -> PARITY.
REQ-018 PARITY: capture bit; frame parity SHALL be odd over 8 data bits plus parity bit -> STOP.
REQ-019 STOP: strobe with data 1 and odd parity good -> byte accepted, IDLE; otherwise discard byte, pulse frame_err, IDLE.
REQ-020 In DATA/PARITY/STOP, TIMEOUT cycles without strobe SHALL force IDLE, clear shift register, pulse frame_err.
REQ-021 Accepted 8'hF0 SHALL set break flag; accepted 8'hE0 SHALL set extended flag; neither produces output.
REQ-022 Accepted non-prefix byte with break or extended flag set SHALL be ignored and clear both flags.
REQ-023 Accepted plain byte equal to KEY_2/KEY_1/KEY_0 SHALL load 3'b100/3'b010/3'b001 into p1_choice and pulse choice_valid the clk cycle after the stop-bit strobe.
REQ-024 Unmapped plain byte SHALL leave p1_choice unchanged, no choice_valid.
REQ-025 Repeated make of same key (typematic) SHALL pulse choice_valid each time; p1_choice value unchanged.
REQ-026 p1_choice SHALL always be exactly one-hot; it holds its value between presses and across errors.
REQ-027 choice_valid and frame_err SHALL never assert in the same cycle.

Reset
REQ-028 reset low SHALL immediately force: FSM IDLE, counters/shift register/flags 0, filtered clock 1, p1_choice 3'b100, choice_valid 0, frame_err 0.
REQ-029 reset asserted mid-frame SHALL discard the partial frame; first frame after release decodes normally.
REQ-030 Outputs SHALL reflect no key press until a complete valid frame follows reset release.

Verification
REQ-031 Frame 8'h1B, odd parity, stop 1 -> p1_choice 3'b010, choice_valid single pulse one cycle after stop strobe.
REQ-032 Sequence 8'h23, 8'hF0, 8'h23 -> p1_choice 3'b001, exactly one choice_valid pulse.
REQ-033 Frame 8'h1C with parity flipped -> frame_err one pulse, p1_choice stays 3'b100, no choice_valid.
REQ-034 4 bits of a frame then idle > TIMEOUT (TIMEOUT=50 in bench) -> frame_err pulse, next frame 8'h1B -> 3'b010.
REQ-035 ps2_clk glitch low for FILTER_LEN-1 cycles mid-bit -> no extra bit sampled, frame decodes correctly.
REQ-036 reset pulled low during DATA of 8'h23 -> p1_choice 3'b100 asynchronously; following 8'h1B -> 3'b010.
